// File: rtl/ddr_req_seq_pkg.sv
// Shared definitions for the DDR request sequencer: FSM state encodings
// and default guard/timeout constants.
package ddr_req_seq_pkg;

   typedef enum logic [2:0] {
      s_IDLE       = 3'd0,
      s_STROBE     = 3'd1,
      s_WAIT_START = 3'd2,
      s_XFER       = 3'd3,
      s_GUARD      = 3'd4
   } state_t;

   // Idle cycles after a line ends (covers tDAL/tRP and the controller input register)
   localparam int GUARD_CLKS_DEF   = 4;
   // Longest wait for the controller data phase before giving up on a line
   localparam int TIMEOUT_CLKS_DEF = 1023;

endpackage

// File: rtl/ddr_req_seq_arb.sv
// Two-way round-robin arbiter between the write-line and read-line clients.
// On a tie the client that did not win last time gets the grant.
module ddr_req_seq_arb (
   input  logic wr_req,
   input  logic rd_req,
   input  logic last_rd,
   output logic grant_wr,
   output logic grant_rd
);

   // One-hot grant; alternate on ties, otherwise pass the lone request through
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (wr_req && rd_req) begin
         grant_rd = !last_rd;
         grant_wr = last_rd;
      end else begin
         grant_wr = wr_req;
         grant_rd = rd_req;
      end
   end

endmodule

// File: rtl/ddr_req_seq.sv
// Request sequencer on the system side of the DDR command controller.
// Grants one line transaction at a time, strobes the controller once,
// follows the wren/readrdy data phase, and enforces an idle guard before
// the controller may be strobed again.
module ddr_req_seq
   import ddr_req_seq_pkg::*;
#(
   parameter int ADDR_W       = 15,
   parameter int GUARD_CLKS   = GUARD_CLKS_DEF,
   parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
   parameter int TO_W         = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sys_init_done,
   input  logic              wren,
   input  logic              readrdy,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_ack,
   output logic              wr_done,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic              rd_done,
   output logic              sys_adsn,
   output logic              sys_r_wn,
   output logic [ADDR_W-1:0] sys_add,
   output logic              busy,
   output logic              timeout_err,
   output logic [2:0]        state
);

   state_t          cur_st;
   logic            last_rd;
   logic [TO_W-1:0] cnt;
   logic            grant_wr;
   logic            grant_rd;
   logic            data_sig;
   logic            cnt_expired;
   logic            guard_end;

   ddr_req_seq_arb u_arb (
      .wr_req   (wr_req),
      .rd_req   (rd_req),
      .last_rd  (last_rd),
      .grant_wr (grant_wr),
      .grant_rd (grant_rd)
   );

   // The registered direction selects which controller data-phase flag is
   // followed, so activity of the other type is ignored
   assign data_sig    = sys_r_wn ? readrdy : wren;
   assign cnt_expired = (cnt == TO_W'(TIMEOUT_CLKS - 1));
   assign guard_end   = (cnt == TO_W'(GUARD_CLKS - 1));
   assign state       = cur_st;

   // Sequencer FSM; every output is a register so the controller sees clean levels
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_st      <= s_IDLE;
         last_rd     <= 1'b0;
         cnt         <= '0;
         wr_ack      <= 1'b0;
         rd_ack      <= 1'b0;
         wr_done     <= 1'b0;
         rd_done     <= 1'b0;
         sys_adsn    <= 1'b1;
         sys_r_wn    <= 1'b1;
         sys_add     <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         wr_ack   <= 1'b0;
         rd_ack   <= 1'b0;
         wr_done  <= 1'b0;
         rd_done  <= 1'b0;
         sys_adsn <= 1'b1;
         case (cur_st)
            s_IDLE: begin
               if (sys_init_done && (grant_wr || grant_rd)) begin
                  wr_ack   <= grant_wr;
                  rd_ack   <= grant_rd;
                  sys_r_wn <= grant_rd;
                  sys_add  <= grant_rd ? rd_addr : wr_addr;
                  last_rd  <= grant_rd;
                  busy     <= 1'b1;
                  cur_st   <= s_STROBE;
               end
            end
            s_STROBE: begin
               sys_adsn <= 1'b0;
               cnt      <= '0;
               cur_st   <= s_WAIT_START;
            end
            s_WAIT_START: begin
               if (data_sig) begin
                  cnt    <= '0;
                  cur_st <= s_XFER;
               end else if (cnt_expired) begin
                  timeout_err <= 1'b1;
                  wr_done     <= !sys_r_wn;
                  rd_done     <= sys_r_wn;
                  cnt         <= '0;
                  cur_st      <= s_GUARD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            s_XFER: begin
               if (!data_sig) begin
                  wr_done <= !sys_r_wn;
                  rd_done <= sys_r_wn;
                  cnt     <= '0;
                  cur_st  <= s_GUARD;
               end else if (cnt_expired) begin
                  timeout_err <= 1'b1;
                  wr_done     <= !sys_r_wn;
                  rd_done     <= sys_r_wn;
                  cnt         <= '0;
                  cur_st      <= s_GUARD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            s_GUARD: begin
               if (guard_end) begin
                  busy   <= 1'b0;
                  cur_st <= s_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy   <= 1'b0;
               cur_st <= s_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ddr_req_seq.md
Name: ddr_req_seq

Overview:
- Request sequencer on the system side of the DDR command controller. It drives the controller's address-strobe, read/write and address inputs.
- Arbitrates between a write-line client (capture path) and a read-line client (remote fetch path).
- Issues one strobe per line transaction and tracks the data phase through the controller's wren/readrdy outputs.
- Reports per-client completion, and guards the controller from being re-strobed while busy.

Parameters:
ADDR_W, 15, width of the line address sent to the controller
GUARD_CLKS, 4, idle cycles after a transaction ends before the next strobe (covers tDAL/tRP plus the controller's input register)
TIMEOUT_CLKS, 1023, maximum cycles in WAIT_START or XFER before the transaction is abandoned
TO_W, 10, width of the timeout/guard counter (must hold TIMEOUT_CLKS)

Ports:
clk  in  1  system clock, shared with the controller
reset  in  1  asynchronous, active-high reset
sys_init_done  in  1  controller initialisation complete
wren  in  1  controller write data phase active
readrdy  in  1  controller read data phase active
wr_req  in  1  write-line request, level
wr_addr  in  ADDR_W  write line address
wr_ack  out  1  one-cycle grant pulse; wr_addr captured this cycle
wr_done  out  1  one-cycle pulse: write line finished or abandoned
rd_req  in  1  read-line request, level
rd_addr  in  ADDR_W  read line address
rd_ack  out  1  one-cycle grant pulse; rd_addr captured this cycle
rd_done  out  1  one-cycle pulse: read line finished or abandoned
sys_adsn  out  1  address strobe to controller, active low
sys_r_wn  out  1  1 = read, 0 = write
sys_add  out  ADDR_W  line address to controller
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set on any timeout, cleared only by reset
state  out  3  current FSM state, for debug

Behaviour:
- Reset values (reset high, asynchronous): sys_adsn=1, sys_r_wn=1, sys_add=0, all ack/done=0, busy=0, timeout_err=0, state=IDLE, last_grant=write, so the first tie goes to read.

States and transitions:
- IDLE: if sys_init_done=0, stay here and ignore requests.
  - Otherwise, if exactly one request is high, grant it.
  - If both are high, grant the client opposite to last_grant.
  - On grant: ack pulses; address and direction are registered; last_grant is updated; go to STROBE.
- STROBE: sys_adsn=0 for exactly this one cycle; go to WAIT_START.
- WAIT_START: wait for wren=1 (write) or readrdy=1 (read), then go to XFER. The counter increments each cycle.
- XFER: wait for the same signal to fall (1→0). On the falling edge, done pulses for the granted client and the FSM goes to GUARD.
- GUARD: count GUARD_CLKS cycles, then go to IDLE.

Timeout:
- The counter resets on entry to WAIT_START and again on entry to XFER.
- Reaching TIMEOUT_CLKS in either state: set timeout_err, pulse the granted client's done, go to GUARD.

Output timing:
- sys_r_wn and sys_add change only at grant. They hold stable from STROBE through GUARD, because the controller samples direction late (ACTIVE/tRCD).
- Grant-to-strobe latency: 1 cycle (ack in cycle N, sys_adsn low in cycle N+1).
- Done-to-next-ack minimum: GUARD_CLKS+1 cycles.

Boundary conditions:
- A request still high after its done is a new request and is re-arbitrated in IDLE.
- Client requirement: drop req in the cycle after ack.
- Request arriving in the same cycle as GUARD exit: it is seen in IDLE the next cycle, never granted early.
- Controller refresh in progress when the strobe lands: handled inside the controller. The sequencer simply waits in WAIT_START, within the timeout.
- wren/readrdy activity of the wrong type during WAIT_START: ignored.
- sys_init_done dropping outside IDLE: no action, finish via the data signals or the timeout.
- Reset mid-transaction: everything returns to reset values immediately; no done pulse.

Decomposition:
- Shared package (ddr_par): state encodings s_IDLE..s_GUARD (3 bits) and the default GUARD/TIMEOUT constants, next to the existing controller constants.
- One sub-module is natural: ddr_req_arb, a two-way round-robin arbiter (req pair plus last_grant in, one-hot grant out, combinational).

Test Plan:
1. Reset, sys_init_done=1, rd_req with rd_addr=15'h0123 -> rd_ack at cycle N; sys_adsn low only at N+1 with sys_r_wn=1, sys_add=0x0123. readrdy high for 100 cycles -> rd_done one cycle after it falls, then 4 idle cycles.
2. wr_req and rd_req raised in the same cycle after reset -> read granted first. Write granted after rd_done+5 cycles, with sys_r_wn=0 and no strobe during GUARD.
3. wr_req held high through wren high/low -> re-granted after guard. Two separate strobes, addresses held stable between grants.
4. Strobe issued, wren never asserts -> after 1023 cycles wr_done pulses and timeout_err=1 and stays set through later good transactions.
5. sys_init_done=0 with both requests high -> no ack and sys_adsn stays 1. Raise sys_init_done -> rd_ack next cycle.
6. Reset asserted during XFER -> sys_adsn=1, busy=0 at once. No done pulse, and the bench checks rd_done/wr_done stay 0 through the reset cycle.
